// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA channel priority resolver.
package dma_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = $clog2(NUM_CH);

  // One-hot resolver states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_LOCKED = 3'b010,
    ST_ACK    = 3'b100
  } resolver_state_e;

  // Return the first set request, scanning upward from start and wrapping.
  // The index arithmetic relies on CH_W bits wrapping naturally at NUM_CH,
  // which holds because NUM_CH is a power of two.
  // An empty request vector returns 0; callers only use the result when a
  // request is present.
  function automatic logic [CH_W-1:0] prio_encode(
    input logic [NUM_CH-1:0] req,
    input logic [CH_W-1:0]   start
  );
    logic [CH_W-1:0] idx;
    logic            found;
    prio_encode = '0;
    found       = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = start + CH_W'(k);
      if (!found && req[idx]) begin
        prio_encode = idx;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Rotating priority encoder: picks the first active request at or after
// start_i, wrapping around the channel set.
import dma_pkg::*;

module dma_priority_encoder (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   start_i,
  output logic [CH_W-1:0]   winner_o
);

  // Pure combinational scan; fixed priority is simply start_i = 0.
  always_comb begin
    winner_o = prio_encode(req_i, start_i);
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// DMA channel arbitration: conditions DREQ, locks a winning channel,
// drives its DACK for the service window and keeps terminal-count flags.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no channel held; arbitrate on any effective request
// LOCKED | winner frozen, waiting for timing and control to assert DACK
// ACK    | DACK driven for the winner until the service ends
import dma_pkg::*;

module dma_priority_resolver #(
  parameter int NUM_CH = dma_pkg::NUM_CH,
  parameter int CH_W   = dma_pkg::CH_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqSense,
  input  logic              dackSense,
  input  logic              rotatingPriority,
  input  logic              controllerDisable,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] softReqReg,
  input  logic              assertDACK,
  input  logic              deassertDACK,
  input  logic              tcEOP,
  input  logic              statusRead,
  output logic              anyRequest,
  output logic              channelValid,
  output logic [CH_W-1:0]   activeChannel,
  output logic [NUM_CH-1:0] DACK,
  output logic [NUM_CH-1:0] clearSoftReq,
  output logic [NUM_CH-1:0] tcStatus
);

  resolver_state_e   state_q, state_d;
  logic [CH_W-1:0]   active_q, active_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] clr_q, clr_d;
  logic [NUM_CH-1:0] tc_q, tc_d;

  logic [NUM_CH-1:0] req_eff;
  logic [CH_W-1:0]   prio_start;
  logic [CH_W-1:0]   winner;

  // Effective requests: sense-corrected DREQ gated by mask, software
  // requests bypass the mask, and the controller disable kills everything.
  always_comb begin
    req_eff    = {NUM_CH{~controllerDisable}} &
                 (((DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg) | softReqReg);
    anyRequest = |req_eff;
    prio_start = rotatingPriority ? last_q + CH_W'(1) : '0;
  end

  dma_priority_encoder u_prio_enc (
    .req_i    (req_eff),
    .start_i  (prio_start),
    .winner_o (winner)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      last_q   <= CH_W'(NUM_CH - 1);
      ack_q    <= '0;
      clr_q    <= '0;
      tc_q     <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
      clr_q    <= clr_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic: arbitration in IDLE only, frozen winner afterwards.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    last_d   = last_q;
    ack_d    = '0;
    clr_d    = '0;
    tc_d     = statusRead ? '0 : tc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (anyRequest) begin
          active_d = winner;
          state_d  = ST_LOCKED;
        end
      end

      ST_LOCKED: begin
        // A simultaneous deassert, or the winner withdrawing, abandons the
        // service without a DACK and without touching rotation.
        if (deassertDACK || !req_eff[active_q]) begin
          state_d = ST_IDLE;
        end else if (assertDACK) begin
          state_d         = ST_ACK;
          ack_d[active_q] = 1'b1;
        end
      end

      ST_ACK: begin
        ack_d[active_q] = 1'b1;
        if (tcEOP) begin
          tc_d[active_q]  = 1'b1;
          clr_d[active_q] = 1'b1;
        end
        if (deassertDACK) begin
          state_d = ST_IDLE;
          last_d  = active_q;
          ack_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; DACK polarity applied after the registered one-hot.
  always_comb begin
    channelValid  = (state_q != ST_IDLE);
    activeChannel = active_q;
    DACK          = ack_q ^ {NUM_CH{~dackSense}};
    clearSoftReq  = clr_q;
    tcStatus      = tc_q;
  end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver with hand-computed expectations.
module tb_dma_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       dreqSense, dackSense, rotatingPriority, controllerDisable;
  logic [3:0] maskReg, softReqReg;
  logic       assertDACK, deassertDACK, tcEOP, statusRead;
  logic       anyRequest, channelValid;
  logic [1:0] activeChannel;
  logic [3:0] DACK, clearSoftReq, tcStatus;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dma_priority_resolver dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .DREQ              (DREQ),
    .dreqSense         (dreqSense),
    .dackSense         (dackSense),
    .rotatingPriority  (rotatingPriority),
    .controllerDisable (controllerDisable),
    .maskReg           (maskReg),
    .softReqReg        (softReqReg),
    .assertDACK        (assertDACK),
    .deassertDACK      (deassertDACK),
    .tcEOP             (tcEOP),
    .statusRead        (statusRead),
    .anyRequest        (anyRequest),
    .channelValid      (channelValid),
    .activeChannel     (activeChannel),
    .DACK              (DACK),
    .clearSoftReq      (clearSoftReq),
    .tcStatus          (tcStatus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // assertDACK for one cycle, then deassertDACK for one cycle
  task automatic service();
    assertDACK = 1'b1;
    tick();
    assertDACK   = 1'b0;
    deassertDACK = 1'b1;
    tick();
    deassertDACK = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; DREQ = '0; dreqSense = 1'b0; dackSense = 1'b1;
    rotatingPriority = 1'b0; controllerDisable = 1'b0;
    maskReg = '0; softReqReg = '0;
    assertDACK = 1'b0; deassertDACK = 1'b0; tcEOP = 1'b0; statusRead = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(channelValid), 32'd0);
    chk("rst_active", 32'(activeChannel), 32'd0);
    chk("rst_dack", 32'(DACK), 32'h0);
    chk("rst_tc", 32'(tcStatus), 32'h0);
    chk("rst_clr", 32'(clearSoftReq), 32'h0);
    RESET_N = 1'b1;
    tick();

    // fixed priority, 1010 -> channel 1
    DREQ = 4'b1010; #1;
    chk("fix_anyreq", 32'(anyRequest), 32'd1);
    tick();
    chk("fix_valid", 32'(channelValid), 32'd1);
    chk("fix_active", 32'(activeChannel), 32'd1);
    chk("fix_dack_pre", 32'(DACK), 32'h0);
    assertDACK = 1'b1; tick(); assertDACK = 1'b0;
    chk("fix_dack", 32'(DACK), 32'h2);
    DREQ = 4'b0000; tick();
    chk("ack_hold", 32'(DACK), 32'h2);
    deassertDACK = 1'b1; tick(); deassertDACK = 1'b0;
    chk("ack_release", 32'(DACK), 32'h0);
    chk("ack_valid_clr", 32'(channelValid), 32'd0);

    // rotating: last served = 1 -> 2, 3, 0
    rotatingPriority = 1'b1; DREQ = 4'b1111;
    tick();
    chk("rot_ch2", 32'(activeChannel), 32'd2);
    service();
    tick();
    chk("rot_ch3", 32'(activeChannel), 32'd3);
    assertDACK = 1'b1; tick(); assertDACK = 1'b0;
    chk("rot_dack3", 32'(DACK), 32'h8);
    deassertDACK = 1'b1; tick(); deassertDACK = 1'b0;
    tick();
    chk("rot_ch0", 32'(activeChannel), 32'd0);
    chk("rot_valid", 32'(channelValid), 32'd1);
    service();
    DREQ = 4'b0000; rotatingPriority = 1'b0;

    // mask, software request, terminal count
    DREQ = 4'b0001; maskReg = 4'b0001; #1;
    chk("mask_anyreq", 32'(anyRequest), 32'd0);
    softReqReg = 4'b0001; #1;
    chk("soft_anyreq", 32'(anyRequest), 32'd1);
    tick();
    chk("soft_active", 32'(activeChannel), 32'd0);
    assertDACK = 1'b1; tick(); assertDACK = 1'b0;
    tcEOP = 1'b1; tick(); tcEOP = 1'b0;
    chk("tc_clr_pulse", 32'(clearSoftReq), 32'h1);
    chk("tc_status", 32'(tcStatus), 32'h1);
    tick();
    chk("tc_clr_end", 32'(clearSoftReq), 32'h0);
    softReqReg = '0; DREQ = '0; maskReg = '0;
    deassertDACK = 1'b1; tick(); deassertDACK = 1'b0;
    chk("tc_sticky", 32'(tcStatus), 32'h1);
    statusRead = 1'b1; tick(); statusRead = 1'b0;
    chk("tc_read_clr", 32'(tcStatus), 32'h0);
    tcEOP = 1'b1; tick(); tcEOP = 1'b0;
    chk("tc_idle_ignored", 32'(tcStatus), 32'h0);

    // withdrawn request from LOCKED, from a fresh reset
    RESET_N = 1'b0; tick(); RESET_N = 1'b1;
    DREQ = 4'b0100; tick();
    chk("wd_active", 32'(activeChannel), 32'd2);
    DREQ = 4'b0000; tick();
    chk("wd_valid", 32'(channelValid), 32'd0);
    chk("wd_dack", 32'(DACK), 32'h0);
    rotatingPriority = 1'b1; DREQ = 4'b1111; tick();
    chk("wd_no_rotate", 32'(activeChannel), 32'd0);
    // assert and deassert together in LOCKED: abandon, no rotation
    assertDACK = 1'b1; deassertDACK = 1'b1; tick();
    assertDACK = 1'b0; deassertDACK = 1'b0;
    chk("both_valid", 32'(channelValid), 32'd0);
    chk("both_dack", 32'(DACK), 32'h0);
    tick();
    chk("both_no_rotate", 32'(activeChannel), 32'd0);
    DREQ = 4'b0000; tick();
    rotatingPriority = 1'b0;

    // active-low DACK with controller disabled
    dackSense = 1'b0; controllerDisable = 1'b1; DREQ = 4'b1011; #1;
    chk("dis_anyreq", 32'(anyRequest), 32'd0);
    chk("dis_dack", 32'(DACK), 32'hF);
    tick();
    chk("dis_valid", 32'(channelValid), 32'd0);

    // reset in the middle of ACK
    dackSense = 1'b1; controllerDisable = 1'b0; DREQ = 4'b0010;
    tick();
    assertDACK = 1'b1; tick(); assertDACK = 1'b0;
    chk("mid_dack", 32'(DACK), 32'h2);
    tcEOP = 1'b1; tick(); tcEOP = 1'b0;
    chk("mid_tc", 32'(tcStatus), 32'h2);
    RESET_N = 1'b0; tick();
    chk("mid_rst_dack", 32'(DACK), 32'h0);
    chk("mid_rst_valid", 32'(channelValid), 32'd0);
    chk("mid_rst_tc", 32'(tcStatus), 32'h0);
    chk("mid_rst_active", 32'(activeChannel), 32'd0);
    RESET_N = 1'b1; DREQ = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
